// File: rtl/core_sub_norm.sv
// Post-subtraction normaliser: shifts a cancelled mantissa left until the hidden
// bit is set, decrementing te_diff with saturation. Define CORE_SUB_LZC_FAST_EN for single-cycle LZC mode.
module core_sub_norm #(
    parameter int MANT_SUB_RESULT_SIZE = 8,
    parameter int TE_BITS              = 8,
    localparam int SW                  = $clog2(MANT_SUB_RESULT_SIZE)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [MANT_SUB_RESULT_SIZE-1:0] mant_i,
    input  logic [TE_BITS-1:0]              te_diff_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [MANT_SUB_RESULT_SIZE-1:0] new_mant_o,
    output logic [TE_BITS-1:0]              new_te_diff_o,
    output logic [SW-1:0]                   shift_amt_o,
    output logic                            is_zero_o,
    output logic                            te_underflow_o
);
    localparam int S = MANT_SUB_RESULT_SIZE;
    localparam logic [S-1:0]       MANT_MASK = {1'b0, {(S-1){1'b1}}};
    localparam logic [TE_BITS-1:0] TE_MIN    = {1'b1, {(TE_BITS-1){1'b0}}};
    localparam logic [SW-1:0]      CNT_ONE   = {{(SW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [S-1:0]        mant_q, mant_d;
    logic [TE_BITS-1:0]  te_q, te_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic                zero_q, zero_d;
    logic                unf_q, unf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [TE_BITS:0]    te_sub_s;

    // Saturating te - amt; returns {underflow, result}.
    function automatic logic [TE_BITS:0] sat_sub(input logic [TE_BITS-1:0] te,
                                                 input logic [SW-1:0] amt);
        logic [TE_BITS:0] diff;
        diff = {te[TE_BITS-1], te} - {{(TE_BITS+1-SW){1'b0}}, amt};
        if (diff[TE_BITS] != diff[TE_BITS-1]) begin
            sat_sub = {1'b1, TE_MIN};
        end else begin
            sat_sub = {1'b0, diff[TE_BITS-1:0]};
        end
    endfunction

    // Leading zeros above the hidden-bit position (input is non-zero when used).
    function automatic logic [SW-1:0] lzc(input logic [S-2:0] m);
        logic [SW-1:0] cnt;
        logic          found;
        cnt   = {SW{1'b0}};
        found = 1'b0;
        for (int i = S - 2; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) begin
                    found = 1'b1;
                end else begin
                    cnt = cnt + CNT_ONE;
                end
            end else begin
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) state_d = SHIFT;
                else            state_d = IDLE;
            end
`ifdef CORE_SUB_LZC_FAST_EN
            SHIFT: state_d = DONE;
`else
            SHIFT: begin
                if (mant_q == {S{1'b0}} || mant_q[S-2]) state_d = DONE;
                else                                    state_d = SHIFT;
            end
`endif
            DONE: begin
                if (out_ready_i) state_d = IDLE;
                else             state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture on accept, normalise in SHIFT, hold otherwise.
    always_comb begin
        mant_d   = mant_q;
        te_d     = te_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        unf_d    = unf_q;
        te_sub_s = {1'b0, te_q};
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    mant_d = mant_i & MANT_MASK;
                    te_d   = te_diff_i;
                    cnt_d  = {SW{1'b0}};
                    zero_d = 1'b0;
                    unf_d  = 1'b0;
                end else begin
                    mant_d = mant_q;
                end
            end
            SHIFT: begin
                if (mant_q == {S{1'b0}}) begin
                    zero_d = 1'b1;
                end else begin
`ifdef CORE_SUB_LZC_FAST_EN
                    cnt_d    = lzc(mant_q[S-2:0]);
                    mant_d   = mant_q << cnt_d;
                    te_sub_s = sat_sub(te_q, cnt_d);
                    te_d     = te_sub_s[TE_BITS-1:0];
                    unf_d    = te_sub_s[TE_BITS];
`else
                    if (!mant_q[S-2]) begin
                        mant_d   = mant_q << 1;
                        cnt_d    = cnt_q + CNT_ONE;
                        te_sub_s = sat_sub(te_q, CNT_ONE);
                        te_d     = te_sub_s[TE_BITS-1:0];
                        // Sticky for the rest of the operation.
                        unf_d    = unf_q | te_sub_s[TE_BITS];
                    end else begin
                        mant_d = mant_q;
                    end
`endif
                end
            end
            DONE:    mant_d = mant_q;
            default: mant_d = mant_q;
        endcase
    end

    // Handshake outputs follow the next state so they are registered.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mant_q      <= {S{1'b0}};
            te_q        <= {TE_BITS{1'b0}};
            cnt_q       <= {SW{1'b0}};
            zero_q      <= 1'b0;
            unf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            mant_q      <= mant_d;
            te_q        <= te_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            unf_q       <= unf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign out_valid_o    = out_valid_q;
    assign new_mant_o     = mant_q;
    assign new_te_diff_o  = te_q;
    assign shift_amt_o    = cnt_q;
    assign is_zero_o      = zero_q;
    assign te_underflow_o = unf_q;

endmodule
